gcd_controller: RTL and testbench

//  FSM that sequences the 8-bit subtract-and-compare GCD datapath: drives mux selects,

---
 rtl/gcd_controller_if.sv | 26 ++
 rtl/gcd_controller.sv | 133 +++++++++++++
 tb/tb_gcd_controller.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/gcd_controller_if.sv
// Control bundle between the GCD sequencer, its host and the subtract/compare datapath.
// master = host plus datapath side, slave = gcd_controller.
interface gcd_controller_if;
   logic start;
   logic a_gt_b;
   logic a_eq_b;
   logic a_lt_b;
   logic a_sel;
   logic b_sel;
   logic a_ld;
   logic b_ld;
   logic output_en;
   logic busy;
   logic done;
   logic err;

   modport master (
      output start, a_gt_b, a_eq_b, a_lt_b,
      input  a_sel, b_sel, a_ld, b_ld, output_en, busy, done, err
   );

   modport slave (
      input  start, a_gt_b, a_eq_b, a_lt_b,
      output a_sel, b_sel, a_ld, b_ld, output_en, busy, done, err
   );
endinterface

// File: rtl/gcd_controller.sv
// Sequencer for the 8-bit subtract-and-compare GCD datapath with start/busy/done handshake.
// Define GCD_WATCHDOG_EN to add the iteration watchdog (iter_cnt, trips at MAX_ITER).
module gcd_controller #(
   parameter int CNT_W    = 8,
   parameter int MAX_ITER = 255
) (
   input logic             clk,
   input logic             rst,
   gcd_controller_if.slave bus
);

   // state | meaning
   // IDLE  | waiting for start; only err may be high
   // LOAD  | A/B registers load the operands
   // CMP   | evaluate datapath flags, pick next step
   // SUB_A | A <= A - B
   // SUB_B | B <= B - A
   // OUT   | out register loads A
   // DONE  | done pulse, result valid
   // FAIL  | done pulse with err, out register untouched
   typedef enum logic [2:0] {
      IDLE, LOAD, CMP, SUB_A, SUB_B, OUT, DONE, FAIL
   } state_t;

   state_t state;
   logic   a_sel_q, b_sel_q, a_ld_q, b_ld_q, output_en_q, busy_q, done_q, err_q;
   logic   wd_trip;

   if (MAX_ITER < 1 || MAX_ITER >= (2 ** CNT_W)) begin : g_bad_param
      $error("gcd_controller: MAX_ITER must lie in 1 .. 2**CNT_W-1");
   end

`ifdef GCD_WATCHDOG_EN
   localparam logic [CNT_W-1:0] ITER_LIMIT = CNT_W'(MAX_ITER);
   logic [CNT_W-1:0] iter_cnt;

   assign wd_trip = (iter_cnt == ITER_LIMIT);

   // saturates at the limit; the CMP check then diverts to FAIL
   always_ff @(posedge clk) begin
      if (rst) begin
         iter_cnt <= '0;
      end else if (state == IDLE && bus.start) begin
         iter_cnt <= '0;
      end else if ((state == SUB_A || state == SUB_B) && !wd_trip) begin
         iter_cnt <= iter_cnt + CNT_W'(1);
      end
   end
`else
   assign wd_trip = 1'b0;
`endif

   // outputs are registered against the state being entered, so they track state exactly
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         a_sel_q     <= 1'b0;
         b_sel_q     <= 1'b0;
         a_ld_q      <= 1'b0;
         b_ld_q      <= 1'b0;
         output_en_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         a_sel_q     <= 1'b0;
         b_sel_q     <= 1'b0;
         a_ld_q      <= 1'b0;
         b_ld_q      <= 1'b0;
         output_en_q <= 1'b0;
         done_q      <= 1'b0;
         busy_q      <= 1'b1;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  state   <= LOAD;
                  a_sel_q <= 1'b1;
                  b_sel_q <= 1'b1;
                  a_ld_q  <= 1'b1;
                  b_ld_q  <= 1'b1;
                  err_q   <= 1'b0;
               end else begin
                  busy_q  <= 1'b0;
               end
            end
            LOAD: state <= CMP;
            CMP: begin
               if (bus.a_eq_b) begin
                  state       <= OUT;
                  output_en_q <= 1'b1;
               end else if (wd_trip) begin
                  state  <= FAIL;
                  done_q <= 1'b1;
                  err_q  <= 1'b1;
               end else if (bus.a_gt_b) begin
                  state  <= SUB_A;
                  a_ld_q <= 1'b1;
               end else if (bus.a_lt_b) begin
                  state  <= SUB_B;
                  b_ld_q <= 1'b1;
               end else begin
                  state  <= FAIL;
                  done_q <= 1'b1;
                  err_q  <= 1'b1;
               end
            end
            SUB_A, SUB_B: state <= CMP;
            OUT: begin
               state  <= DONE;
               done_q <= 1'b1;
            end
            DONE, FAIL: begin
               state  <= IDLE;
               busy_q <= 1'b0;
            end
            default: begin
               state  <= IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.a_sel     = a_sel_q;
   assign bus.b_sel     = b_sel_q;
   assign bus.a_ld      = a_ld_q;
   assign bus.b_ld      = b_ld_q;
   assign bus.output_en = output_en_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.err       = err_q;

endmodule

// File: tb/tb_gcd_controller.sv
// Bench for gcd_controller: drives it beside a behavioural 8-bit datapath and checks
// latency, subtraction order, result, err and handshake against an arithmetic GCD model.
module tb_gcd_controller;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] in1, in2, ra, rb, rout;
   logic       ovr_en;
   logic [2:0] ovr;              // {gt, eq, lt} forced onto the flags when ovr_en
   int         checks   = 0;
   int         failures = 0;
   bit         exp_seq[$];       // 0 = A-B step, 1 = B-A step

   gcd_controller_if bus();

   gcd_controller dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.a_ld)      ra   <= bus.a_sel ? in1 : ra - rb;
      if (bus.b_ld)      rb   <= bus.b_sel ? in2 : rb - ra;
      if (bus.output_en) rout <= ra;
   end

   assign bus.a_gt_b = ovr_en ? ovr[2] : (ra > rb);
   assign bus.a_eq_b = ovr_en ? ovr[1] : (ra == rb);
   assign bus.a_lt_b = ovr_en ? ovr[0] : (ra < rb);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   function automatic int gcd_mod(input int x, input int y);
      int t;
      while (y != 0) begin
         t = x % y;
         x = y;
         y = t;
      end
      return x;
   endfunction

   // subtraction steps the datapath will take, recorded in exp_seq
   task automatic model_steps(input int x, input int y, output int ka, output int kb);
      exp_seq.delete();
      ka = 0;
      kb = 0;
      while (x != y) begin
         if (x > y) begin x -= y; ka++; exp_seq.push_back(1'b0); end
         else       begin y -= x; kb++; exp_seq.push_back(1'b1); end
      end
   endtask

   task automatic run_op(input string tag, input logic [7:0] x, input logic [7:0] y,
                         input logic [7:0] exp_out, input int exp_cyc, input logic exp_err,
                         input int exp_ka, input int exp_kb, input int glitch_at);
      int cyc, ka, kb, loads, busy_low;
      bit order_ok;
      ka = 0; kb = 0; loads = 0; busy_low = 0; order_ok = 1;
      in1 = x;
      in2 = y;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      cyc = 1;
      while (cyc <= exp_cyc + 20) begin
         if (!bus.busy) busy_low++;
         if (bus.a_ld && bus.a_sel && bus.b_ld && bus.b_sel) loads++;
         if (bus.a_ld && !bus.a_sel) begin
            ka++;
            if (exp_seq.size() == 0 || exp_seq.pop_front() != 1'b0) order_ok = 0;
         end
         if (bus.b_ld && !bus.b_sel) begin
            kb++;
            if (exp_seq.size() == 0 || exp_seq.pop_front() != 1'b1) order_ok = 0;
         end
         bus.start = (cyc == glitch_at);
         if (bus.done) break;
         @(posedge clk); #1;
         cyc++;
      end
      bus.start = 1'b0;
      chk({tag, ".done_cycle"}, cyc, exp_cyc);
      chk({tag, ".err"}, bus.err, exp_err);
      chk({tag, ".sub_a"}, ka, exp_ka);
      chk({tag, ".sub_b"}, kb, exp_kb);
      chk({tag, ".order"}, {31'd0, order_ok && exp_seq.size() == 0}, 1);
      chk({tag, ".single_load"}, loads, 1);
      chk({tag, ".busy_gap"}, busy_low, 0);
      @(posedge clk); #1;
      chk({tag, ".out"}, rout, exp_out);
      chk({tag, ".done_width"}, bus.done, 0);
      chk({tag, ".idle_busy"}, bus.busy, 0);
      @(posedge clk); #1;
      chk({tag, ".not_queued"}, bus.busy, 0);
   endtask

   task automatic run_gcd(input string tag, input int x, input int y, input int glitch_at);
      int ka, kb;
      model_steps(x, y, ka, kb);
      run_op(tag, 8'(x), 8'(y), 8'(gcd_mod(x, y)), 2 * (ka + kb) + 4, 1'b0, ka, kb, glitch_at);
   endtask

   initial begin
      int x, y, cyc, ka, kb, done_cnt, busy_low;
      logic [7:0] prev_out;
      bit seen;

      ra = '0; rb = '0; rout = '0; in1 = '0; in2 = '0;
      ovr_en = 1'b0; ovr = 3'b000;

      // reset with start held high
      rst = 1'b1;
      bus.start = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst.outputs", {bus.a_sel, bus.b_sel, bus.a_ld, bus.b_ld, bus.output_en,
                          bus.busy, bus.done, bus.err}, 0);
      bus.start = 1'b0;
      rst = 1'b0;
      @(posedge clk); #1;
      chk("rst.start_ignored", bus.busy, 0);

      run_gcd("g12_8", 12, 8, 0);
      run_gcd("g9_9", 9, 9, 0);
      run_gcd("g255_1", 255, 1, 0);
      run_gcd("g1_255", 1, 255, 0);

      for (int i = 0; i < 8; i++) begin
         x = int'($urandom_range(1, 255));
         y = int'($urandom_range(1, 255));
         run_gcd($sformatf("rnd%0d", i), x, y, 0);
      end

      // reset during SUB_B of 12/8
      in1 = 8'd12; in2 = 8'd8;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      seen = 0;
      for (int c = 0; c < 20 && !seen; c++) begin
         if (bus.b_ld && !bus.b_sel) seen = 1;
         else begin @(posedge clk); #1; end
      end
      chk("abort.reached_sub_b", {31'd0, seen}, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort.outputs", {bus.a_ld, bus.b_ld, bus.output_en, bus.busy, bus.done}, 0);
      run_gcd("g12_8_after_abort", 12, 8, 3);
      run_gcd("g100_75_glitch", 100, 75, 7);

      // start held high: exactly one IDLE cycle between operations
      in1 = 8'd12; in2 = 8'd8;
      bus.start = 1'b1;
      @(posedge clk); #1;
      cyc = 1;
      while (!bus.done && cyc < 40) begin @(posedge clk); #1; cyc++; end
      chk("b2b.first_done", cyc, 8);
      @(posedge clk); #1;
      chk("b2b.idle_gap", {bus.busy, bus.done}, 2'b00);
      @(posedge clk); #1;
      chk("b2b.reload", {bus.busy, bus.a_ld, bus.a_sel}, 3'b111);
      bus.start = 1'b0;
      cyc = 1;
      while (!bus.done && cyc < 40) begin @(posedge clk); #1; cyc++; end
      chk("b2b.second_done", cyc, 8);
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("b2b.out", rout, 4);

      // no compare flag -> FAIL, out untouched, err held until next start
      prev_out = rout;
      ovr_en = 1'b1;
      ovr = 3'b000;
      exp_seq.delete();
      run_op("noflag", 8'd3, 8'd5, prev_out, 3, 1'b1, 0, 0, 0);
      chk("noflag.err_held", bus.err, 1);
      // eq outranks gt and lt
      ovr = 3'b110;
      exp_seq.delete();
      run_op("eq_gt", 8'd5, 8'd3, 8'd5, 4, 1'b0, 0, 0, 0);
      ovr = 3'b111;
      exp_seq.delete();
      run_op("eq_gt_lt", 8'd6, 8'd2, 8'd6, 4, 1'b0, 0, 0, 0);
      ovr_en = 1'b0;

      // zero operand
      prev_out = rout;
`ifdef GCD_WATCHDOG_EN
      exp_seq.delete();
      for (int i = 0; i < 255; i++) exp_seq.push_back(1'b0);
      run_op("wd7_0", 8'd7, 8'd0, prev_out, 513, 1'b1, 255, 0, 0);
      run_gcd("after_wd", 6, 4, 0);
`else
      in1 = 8'd7; in2 = 8'd0;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      done_cnt = 0; busy_low = 0;
      for (int c = 0; c < 600; c++) begin
         if (bus.done) done_cnt++;
         if (!bus.busy) busy_low++;
         @(posedge clk); #1;
      end
      chk("zero.no_done", done_cnt, 0);
      chk("zero.stays_busy", busy_low, 0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("zero.reset_idle", bus.busy, 0);
      chk("zero.out_kept", rout, prev_out);
      model_steps(6, 4, ka, kb);
      run_op("after_zero", 8'd6, 8'd4, 8'(gcd_mod(6, 4)), 2 * (ka + kb) + 4, 1'b0, ka, kb, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
